// File: rtl/alu_cmd_driver_if.sv
// Command, ALU-core and response signals of the tinyalu requester.
// master = the driver block, slave = command source / core / response sink side.
interface alu_cmd_driver_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [7:0]  cmd_a;
  logic [7:0]  cmd_b;
  logic        alu_start;
  logic [2:0]  alu_op;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic        alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_timeout;
  logic        busy;

  modport master (
    input  cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
    output cmd_ready, alu_start, alu_op, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_op, rsp_timeout, busy
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_a, cmd_b, alu_done, alu_result, rsp_ready,
    input  cmd_ready, alu_start, alu_op, alu_a, alu_b,
           rsp_valid, rsp_result, rsp_op, rsp_timeout, busy
  );
endinterface

// File: rtl/alu_cmd_driver.sv
// Requester for the tinyalu start/done core: queues commands, issues them one
// at a time, and returns results in order on a valid/ready response stream.
module alu_cmd_driver #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic               clk,
  input  logic               reset_n,
  alu_cmd_driver_if.master   bus
);
  localparam int AW = $clog2(FIFO_DEPTH);

  typedef struct packed {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
  } cmd_t;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  cmd_t          mem [FIFO_DEPTH];
  logic [AW:0]   wptr, rptr;
  logic          full, empty, push, pop;
  cmd_t          head;

  state_t        state_q, state_d;
  logic          start_q, start_d;
  logic [2:0]    op_q, op_d;
  logic [7:0]    a_q, a_d, b_q, b_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          rv_q, rv_d, rto_q, rto_d;
  logic [15:0]   rres_q, rres_d;
  logic [2:0]    rop_q, rop_d;

  // Extra pointer bit distinguishes full from empty.
  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign push  = bus.cmd_valid && !full;
  assign head  = mem[rptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) mem[wptr[AW-1:0]] <= '{op: bus.cmd_op, a: bus.cmd_a, b: bus.cmd_b};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    rv_d    = rv_q && !bus.rsp_ready;
    rres_d  = rres_q;
    rop_d   = rop_q;
    rto_d   = rto_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!empty && (!rv_q || bus.rsp_ready)) begin
          pop = 1'b1;
          if (head.op != 3'b000) begin
            start_d = 1'b1;
            op_d    = head.op;
            a_d     = head.a;
            b_d     = head.b;
            cnt_d   = '0;
            state_d = ISSUE;
          end else begin
            // no_op never reaches the core; answer it directly
            rv_d   = 1'b1;
            rres_d = '0;
            rop_d  = 3'b000;
            rto_d  = 1'b0;
          end
        end
      end
      ISSUE: begin
        if (bus.alu_done) begin
          start_d = 1'b0;
          rv_d    = 1'b1;
          rres_d  = bus.alu_result;
          rop_d   = op_q;
          rto_d   = 1'b0;
          state_d = DRAIN;
        end else if (cnt_q == 8'(TIMEOUT - 1)) begin
          start_d = 1'b0;
          rv_d    = 1'b1;
          rres_d  = '0;
          rop_d   = op_q;
          rto_d   = 1'b1;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DRAIN: begin
        // core holds done for two cycles after start falls
        if (!bus.alu_done) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rv_q    <= 1'b0;
      rres_q  <= '0;
      rop_q   <= '0;
      rto_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rv_q    <= rv_d;
      rres_q  <= rres_d;
      rop_q   <= rop_d;
      rto_q   <= rto_d;
    end
  end

  assign bus.cmd_ready   = !full;
  assign bus.alu_start   = start_q;
  assign bus.alu_op      = op_q;
  assign bus.alu_a       = a_q;
  assign bus.alu_b       = b_q;
  assign bus.rsp_valid   = rv_q;
  assign bus.rsp_result  = rres_q;
  assign bus.rsp_op      = rop_q;
  assign bus.rsp_timeout = rto_q;
  assign bus.busy        = (state_q != IDLE) || !empty || rv_q;
endmodule

// File: tb/tb_alu_cmd_driver.sv
// Scoreboard bench for alu_cmd_driver with a two-register-done tinyalu core model.
module tb_alu_cmd_driver;
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  alu_cmd_driver_if bus ();

  alu_cmd_driver #(.FIFO_DEPTH(4), .TIMEOUT(15)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [15:0] res;
    logic        tmo;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Core model: done appears two edges after start is sampled high, and
  // lingers two edges after start falls. hang suppresses done entirely.
  logic        hang;
  logic        d1, d2;
  logic [15:0] res_r;

  function automatic logic [15:0] core_f(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd1:    core_f = {8'd0, a} + {8'd0, b};
      3'd2:    core_f = {8'd0, a & b};
      3'd3:    core_f = {8'd0, a ^ b};
      3'd4:    core_f = a * b;
      default: core_f = '0;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      d1 <= 1'b0; d2 <= 1'b0; res_r <= '0;
    end else begin
      d1 <= bus.alu_start && !hang;
      d2 <= d1;
      if (bus.alu_start) res_r <= core_f(bus.alu_op, bus.alu_a, bus.alu_b);
    end
  end
  assign bus.alu_done   = d2;
  assign bus.alu_result = res_r;

  // Response monitor: a handshake visible at negedge completes on the next edge.
  always @(negedge clk) begin
    if (reset_n && bus.rsp_valid && bus.rsp_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("rsp_result",  32'(bus.rsp_result),  32'(e.res));
        chk("rsp_op",      32'(bus.rsp_op),      32'(e.op));
        chk("rsp_timeout", 32'(bus.rsp_timeout), 32'(e.tmo));
      end
    end
  end

  // Start-pulse monitor: length, operand stability, low gap between issues.
  int         exp_len;
  int         st_len, gap, n_starts;
  logic       prev_st, seen_fall, stable;
  logic [2:0] l_op;
  logic [7:0] l_a, l_b;

  always @(negedge clk) begin
    if (!reset_n) begin
      prev_st = 1'b0; seen_fall = 1'b0; st_len = 0; gap = 0;
    end else begin
      if (bus.alu_start && !prev_st) begin
        if (seen_fall) chk("start_gap_ge3", 32'(gap >= 3), 32'd1);
        l_op = bus.alu_op; l_a = bus.alu_a; l_b = bus.alu_b;
        st_len = 1; stable = 1'b1; n_starts++;
      end else if (bus.alu_start) begin
        st_len++;
        if (bus.alu_op != l_op || bus.alu_a != l_a || bus.alu_b != l_b) stable = 1'b0;
      end else if (prev_st) begin
        chk("start_len", 32'(st_len), 32'(exp_len));
        chk("opnd_stable", 32'(stable), 32'd1);
        seen_fall = 1'b1;
        gap = 1;
      end else begin
        gap++;
      end
      prev_st = bus.alu_start;
    end
  end

  task automatic push(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                      input logic [15:0] er, input logic et);
    int n;
    exp_t e;
    n = 0;
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_a = a; bus.cmd_b = b;
    @(negedge clk);
    while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
    if (!bus.cmd_ready) begin
      chk("cmd_accept_wait", 32'd0, 32'd1);
    end else begin
      e.op = op; e.res = er; e.tmo = et;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk); #1; n++;
    end while ((sb.size() != 0 || bus.busy) && n < 400);
    if (sb.size() != 0 || bus.busy) chk("idle_wait", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    reset_n = 1'b0; hang = 1'b0; exp_len = 3; n_starts = 0; stable = 1'b1;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_a = '0; bus.cmd_b = '0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_alu_start", 32'(bus.alu_start), 32'd0);
    chk("rst_alu_op",    32'(bus.alu_op),    32'd0);
    chk("rst_alu_a",     32'(bus.alu_a),     32'd0);
    chk("rst_alu_b",     32'(bus.alu_b),     32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_res",   32'(bus.rsp_result),32'd0);
    chk("rst_rsp_op",    32'(bus.rsp_op),    32'd0);
    chk("rst_rsp_tmo",   32'(bus.rsp_timeout),32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    @(negedge clk); reset_n = 1'b1;

    // add
    push(3'd1, 8'h12, 8'h34, 16'h0046, 1'b0);
    wait_idle();

    // back-to-back and/xor, then a pass-through op
    push(3'd2, 8'hFF, 8'h0F, 16'h000F, 1'b0);
    push(3'd3, 8'hAA, 8'h55, 16'h00FF, 1'b0);
    push(3'd4, 8'h10, 8'h10, 16'h0100, 1'b0);
    wait_idle();

    // no_op must not reach the core
    s0 = n_starts;
    push(3'd0, 8'h05, 8'h07, 16'h0000, 1'b0);
    wait_idle();
    chk("noop_no_start", 32'(n_starts - s0), 32'd0);

    // backpressure: cmd1 parks in the response register, 2..5 fill the FIFO
    bus.rsp_ready = 1'b0;
    for (int i = 1; i <= 5; i++)
      push(3'd1, 8'(i * 16), 8'(i), 16'(i * 17), 1'b0);
    repeat (20) @(posedge clk);
    #1;
    chk("full_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("full_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    chk("full_rsp_hold",  32'(bus.rsp_result), 32'h0011);
    chk("full_busy",      32'(bus.busy), 32'd1);
    bus.rsp_ready = 1'b1;
    push(3'd1, 8'h60, 8'h06, 16'h0066, 1'b0);
    wait_idle();

    // timeout: core never answers
    hang = 1'b1; exp_len = 15;
    push(3'd1, 8'h01, 8'h01, 16'h0000, 1'b1);
    wait_idle();
    hang = 1'b0; exp_len = 3;
    push(3'd1, 8'h02, 8'h03, 16'h0005, 1'b0);
    wait_idle();

    // reset while a command is in ISSUE with two more queued
    hang = 1'b1;
    push(3'd1, 8'h11, 8'h11, 16'h0022, 1'b0);
    push(3'd2, 8'h33, 8'h0F, 16'h0003, 1'b0);
    push(3'd3, 8'h44, 8'h0F, 16'h004B, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("pre_rst_start", 32'(bus.alu_start), 32'd1);
    reset_n = 1'b0;
    #1;
    chk("rst_async_start", 32'(bus.alu_start), 32'd0);
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    hang = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("post_rst_busy",      32'(bus.busy),      32'd0);
    chk("post_rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
    repeat (30) @(posedge clk);
    #1;
    chk("post_rst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/alu_cmd_driver.md
# alu_cmd_driver

Requester side of the tinyalu start/done command interface. Accepts ALU commands from an upstream valid/ready stream into a small FIFO. Drives `start`/`op`/`A`/`B` into the ALU core, holds them until `done`, captures the 16-bit result and returns it on a downstream valid/ready response stream. Sits between the testbench/host command source and the ALU datapath. Enforces the core's protocol rules: operands stable while start is high, no start for no_op, and a drain gap before re-issue.

## Interface
- `FIFO_DEPTH`, default 4: command FIFO entries; power of 2, ≥2.
- `TIMEOUT`, default 15: max cycles `alu_start` stays high without `alu_done`; range 4..255.

Ports (`clk` and `reset_n` first):
- `clk` in 1: single clock; all logic on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `cmd_valid` in 1: upstream command valid.
- `cmd_ready` out 1: FIFO not full.
- `cmd_op` in 3: operation code (000 no_op, 001 add, 010 and, 011 xor, others passed through).
- `cmd_a` in 8: operand A.
- `cmd_b` in 8: operand B.
- `alu_start` out 1: start to ALU core.
- `alu_op` out 3: op to ALU core.
- `alu_a` out 8: operand A to ALU core.
- `alu_b` out 8: operand B to ALU core.
- `alu_done` in 1: done from ALU core.
- `alu_result` in 16: result from ALU core; valid while `alu_done`=1.
- `rsp_valid` out 1: response valid.
- `rsp_ready` in 1: downstream accepts response.
- `rsp_result` out 16: captured result.
- `rsp_op` out 3: op of the completed command.
- `rsp_timeout` out 1: command ended by timeout.
- `busy` out 1: `state`≠IDLE, or FIFO non-empty, or `rsp_valid`.

## Operation
- Command push: on `cmd_valid && cmd_ready`, write {op,a,b}. There is no bypass. An empty FIFO costs one cycle.
- FSM states: IDLE, ISSUE, DRAIN.
- **IDLE**: FIFO non-empty and response slot free (`!rsp_valid || rsp_ready`) → pop the FIFO head.
  - If op≠000: load `alu_op`/`alu_a`/`alu_b`, set `alu_start`=1, clear timeout counter, go to ISSUE.
  - If op=000: do not assert start. Load the response register with result 0x0000, timeout 0. Stay in IDLE.
- **ISSUE**: `alu_start`, `alu_op`, `alu_a`, `alu_b` held constant.
  - On an edge sampling `alu_done`=1: capture `alu_result` into `rsp_result`, `rsp_op`=`alu_op`, `rsp_timeout`=0, `rsp_valid`=1, `alu_start`=0, go to DRAIN.
  - Timeout counter increments each ISSUE cycle. On reaching `TIMEOUT` without done: `alu_start`=0, response result 0x0000, `rsp_timeout`=1, go to DRAIN.
- **DRAIN**: `alu_start`=0. Exit to IDLE on the first edge sampling `alu_done`=0. Needed because the core's done stays high for two cycles after start falls.
- Response register: `rsp_valid` clears on `rsp_valid && rsp_ready` unless reloaded on the same edge. Load and consume on the same edge is legal; the new response wins.
- Responses are strictly in command order.
- `alu_op`/`alu_a`/`alu_b` keep their last value outside ISSUE.
- A late done arriving after timeout is absorbed by DRAIN only if it is high when DRAIN is entered. Otherwise it is ignored in IDLE, because done is only sampled in ISSUE.

## Timing
- Reset values: `alu_start`=0, `alu_op`=0, `alu_a`=0, `alu_b`=0, `rsp_valid`=0, `rsp_result`=0x0000, `rsp_op`=0, `rsp_timeout`=0, `busy`=0. `cmd_ready`=1. FIFO is empty.
- Reset mid-operation: `alu_start` drops asynchronously. The FIFO and the in-flight command are discarded.
- Command accepted at edge E with the FIFO empty and the FSM in IDLE: `alu_start` rises at E+1 (edge k).
- Single-cycle op sequence, with the core's two-register done path:
  - `alu_done` is high after k+2.
  - Capture happens at k+3; `alu_start` falls and `rsp_valid` rises at k+3. `alu_start` is high exactly 3 cycles.
  - `alu_done` stays high through k+4 and is low after k+5.
  - DRAIN exits at k+6. The next `alu_start` rises no earlier than k+6, giving a gap of ≥3 low cycles.
- No_op: `rsp_valid` rises on the pop edge. The next command may pop on the following edge if the response is consumed.
- Timeout: `alu_start` is high exactly `TIMEOUT` cycles. `rsp_valid` rises on the edge it falls.
- Full: `cmd_ready`=0 when FIFO_DEPTH entries are stored. A pop frees the slot for the next cycle, not the same edge.

## Test plan
- Add: op=001, A=0x12, B=0x34, `rsp_ready`=1 → `rsp_result`=0x0046, `rsp_op`=001, `rsp_timeout`=0; `alu_start` high exactly 3 cycles.
- Back-to-back: and 0xFF,0x0F then xor 0xAA,0x55 → responses 0x000F then 0x00FF in order; `alu_start` low ≥3 cycles between the commands; operands stable while start is high.
- No_op: op=000, A=0x05, B=0x07 → `alu_start` never asserts; response 0x0000, `rsp_op`=000, `rsp_timeout`=0.
- Backpressure/full: `rsp_ready`=0, push 6 adds →
  - cmd1 completes into the response register; cmds 2–5 fill the FIFO; `cmd_ready`=0 so cmd6 stalls.
  - Raising `rsp_ready` drains all 6 in order with correct sums.
- Timeout: ALU model holds `alu_done`=0, op=001 → `alu_start` high 15 cycles, then response 0x0000 with `rsp_timeout`=1; FSM returns to IDLE.
- Reset mid-ISSUE: `reset_n`=0 while `alu_start`=1 with 2 commands queued →
  - `alu_start`=0 immediately; `rsp_valid`=0, `busy`=0, `cmd_ready`=1 after release.
  - No response ever appears for the discarded commands.
